// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with shadowed inputs.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros on positions 3..1.
module seg7_scan_driver #(
   parameter int SCAN_DIV_W  = 17,
   parameter int BLINK_DIV_W = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic [3:0]  blank_mask,
   input  logic [3:0]  blink_mask,
   input  logic [3:0]  dp_mask,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frame_tick
);

   logic [SCAN_DIV_W-1:0]  presc_q;
   logic [1:0]             pos_q;
   logic [BLINK_DIV_W-1:0] frame_cnt_q;
   logic [15:0]            dig_q;
   logic [3:0]             blank_q, blink_q, dp_q;
   logic [3:0]             an_q, an_d;
   logic [7:0]             seg_q, seg_d;
   logic                   frame_tick_q;

   logic       scan_tick;
   logic       blink_phase;
   logic [3:0] nib;
   logic [6:0] glyph;
   logic [3:0] lz_blank;
   logic       dark;

   assign scan_tick   = &presc_q;
   assign blink_phase = frame_cnt_q[BLINK_DIV_W-1];

   // pos_q names the position that the next scan tick lights; after reset the first tick lights position 0.
   assign nib = dig_q[{pos_q, 2'b00} +: 4];

   always_comb begin
      glyph = 7'b1111111;
      case (nib)
         4'h0: glyph = 7'b0000001;
         4'h1: glyph = 7'b1001111;
         4'h2: glyph = 7'b0010010;
         4'h3: glyph = 7'b0000110;
         4'h4: glyph = 7'b1001100;
         4'h5: glyph = 7'b0100100;
         4'h6: glyph = 7'b0100000;
         4'h7: glyph = 7'b0001111;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0000100;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b1100000;
         4'hC: glyph = 7'b0110001;
         4'hD: glyph = 7'b1000010;
         4'hE: glyph = 7'b0110000;
         4'hF: glyph = 7'b0111000;
         default: glyph = 7'b1111111;
      endcase
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // A position is a leading zero only if it and everything to its left is zero.
   always_comb begin
      lz_blank    = 4'b0000;
      lz_blank[3] = (dig_q[15:12] == 4'h0);
      lz_blank[2] = lz_blank[3] & (dig_q[11:8] == 4'h0);
      lz_blank[1] = lz_blank[2] & (dig_q[7:4] == 4'h0);
   end
`else
   assign lz_blank = 4'b0000;
`endif

   always_comb begin
      dark  = blank_q[pos_q] | lz_blank[pos_q] | (blink_q[pos_q] & blink_phase);
      an_d  = 4'b1111;
      seg_d = 8'hFF;
      if (!dark) begin
         an_d  = ~(4'b0001 << pos_q);
         seg_d = {glyph, ~dp_q[pos_q]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         pos_q        <= 2'd0;
         frame_cnt_q  <= '0;
         dig_q        <= 16'h0000;
         blank_q      <= 4'h0;
         blink_q      <= 4'h0;
         dp_q         <= 4'h0;
         an_q         <= 4'hF;
         seg_q        <= 8'hFF;
         frame_tick_q <= 1'b0;
      end else begin
         presc_q      <= presc_q + SCAN_DIV_W'(1);
         frame_tick_q <= scan_tick && (pos_q == 2'd3);
         if (scan_tick) begin
            pos_q <= pos_q + 2'd1;
            an_q  <= an_d;
            seg_q <= seg_d;
         end
         if (frame_tick_q) begin
            frame_cnt_q <= frame_cnt_q + BLINK_DIV_W'(1);
         end
         // A load on a tick edge lands after the tick has sampled the old shadow.
         if (load) begin
            dig_q   <= digits_in;
            blank_q <= blank_mask;
            blink_q <= blink_mask;
            dp_q    <= dp_mask;
         end
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a tick/frame-count reference model (SCAN_DIV_W=2, BLINK_DIV_W=2).
// Honours SEG7_LEADING_ZERO_BLANK_EN in its model when the build defines it.
module tb_seg7_scan_driver;

   localparam int SW = 2;
   localparam int BW = 2;
   localparam int TICK_PERIOD = 1 << SW;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digits_in = 16'h0000;
   logic [3:0]  blank_mask = 4'h0, blink_mask = 4'h0, dp_mask = 4'h0;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frame_tick;

   seg7_scan_driver #(.SCAN_DIV_W(SW), .BLINK_DIV_W(BW)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
      .blank_mask(blank_mask), .blink_mask(blink_mask), .dp_mask(dp_mask),
      .an(an), .seg(seg), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: edges since reset release, ticks so far, shadow copy of the inputs.
   int          edge_cnt, tick_cnt;
   logic [15:0] m_dig;
   logic [3:0]  m_blank, m_blink, m_dp;
   logic [3:0]  e_an;
   logic [7:0]  e_seg;
   logic        e_ft;

   function automatic logic [6:0] glyph_of(input int v);
      logic [6:0] tbl [16];
      tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
              7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      return tbl[v];
   endfunction

   function automatic logic [11:0] expect_out(input int p, input int frame);
      bit dark;
      int v;
      v    = (int'(m_dig) >> (4 * p)) % 16;
      dark = m_blank[p] || (m_blink[p] && ((frame % (1 << BW)) >= (1 << (BW - 1))));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (p != 0 && (int'(m_dig) >> (4 * p)) == 0) dark = 1;
`endif
      if (dark) return {4'hF, 8'hFF};
      return {4'hF & ~(4'b0001 << p), glyph_of(v), ~m_dp[p]};
   endfunction

   task automatic model_reset();
      edge_cnt = 0; tick_cnt = 0;
      m_dig = 16'h0; m_blank = 4'h0; m_blink = 4'h0; m_dp = 4'h0;
      e_an = 4'hF; e_seg = 8'hFF; e_ft = 1'b0;
   endtask

   // Advance one clock with rst_n high, update the model, compare on the falling edge.
   task automatic cycle();
      @(posedge clk);
      e_ft = 1'b0;
      if (edge_cnt % TICK_PERIOD == TICK_PERIOD - 1) begin
         {e_an, e_seg} = expect_out(tick_cnt % 4, tick_cnt / 4);
         if (tick_cnt % 4 == 3) e_ft = 1'b1;
         tick_cnt++;
      end
      edge_cnt++;
      if (load) begin
         m_dig = digits_in; m_blank = blank_mask; m_blink = blink_mask; m_dp = dp_mask;
      end
      @(negedge clk);
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("frame_tick", 32'(frame_tick), 32'(e_ft));
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'hFF);
      check("rst_ft", 32'(frame_tick), 32'h0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                        input logic [3:0] dp);
      load = 1'b1; digits_in = d; blank_mask = bl; blink_mask = bk; dp_mask = dp;
      cycle();
      load = 1'b0;
   endtask

   logic [3:0] exp_an_t [4];
   logic [7:0] exp_seg_t [4];

   initial begin
      model_reset();
      exp_an_t  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg_t = '{8'b11000001, 8'b00100101, 8'b00010001, 8'b10011111};

      // Reset release, then a decode frame starting from the very first tick.
      @(negedge clk);
      do_reset();
      drive(16'h1A2B, 4'h0, 4'h0, 4'h0);
      for (int i = 1; i < 16; i++) begin
         cycle();
         if (i % 4 == 3) begin
            check("decode_an", 32'(an), 32'(exp_an_t[i / 4]));
            check("decode_seg", 32'(seg), 32'(exp_seg_t[i / 4]));
         end
      end
      repeat (4) cycle();

      // Masks, blink across several frames, leading-zero patterns.
      drive(16'h8888, 4'b0100, 4'h0, 4'b0001);
      repeat (20) cycle();
      drive(16'h1234, 4'h0, 4'b0001, 4'h0);
      repeat (96) cycle();
      drive(16'h0070, 4'h0, 4'h0, 4'h0);
      repeat (20) cycle();
      drive(16'h0000, 4'h0, 4'h0, 4'h0);
      repeat (20) cycle();

      // Load coincident with the tick that lights position 0.
      drive(16'h0009, 4'h0, 4'h0, 4'h0);
      begin
         int guard;
         guard = 0;
         while (!(edge_cnt % TICK_PERIOD == TICK_PERIOD - 1 && tick_cnt % 4 == 0) && guard < 64) begin
            cycle();
            guard++;
         end
         check("race_align", 32'(guard < 64), 32'h1);
      end
      drive(16'h0005, 4'h0, 4'h0, 4'h0);
      check("race_old", 32'(seg), 32'({7'b0000100, 1'b1}));
      repeat (16) cycle();
      check("race_new", 32'(seg), 32'({7'b0100100, 1'b1}));

      // Randomized loads, held loads and a reset in the middle.
      for (int it = 0; it < 300; it++) begin
         if (it == 150) begin
            repeat ($urandom_range(0, 3)) cycle();
            do_reset();
         end
         if ($urandom_range(0, 3) == 0) begin
            load       = 1'b1;
            digits_in  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            blank_mask = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            blink_mask = 4'($urandom);
            dp_mask    = 4'($urandom);
         end else begin
            load = 1'b0;
         end
         repeat ($urandom_range(1, 6)) cycle();
      end
      load = 1'b0;
      repeat (8) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
